calculator_sequencer: RTL and testbench
=======================================

# calculator_sequencer

Initiator-side controller for the 4-bit calculator datapath: accepts one operation request (two 4-bit operands plus an ALU operation), drives the datapath's LOAD A / LOAD B / COMPUTE instruction sequence, waits for the datapath's `done`, then captures and presents the 8-bit result and flags. It sits between user-facing inputs (switches/buttons, already debounced) and the datapath. It owns all instruction sequencing so the datapath stays purely reactive.

## Interface
- `TIMEOUT_CYCLES`, default 16: maximum cycles spent in COMPUTE waiting for `dp_done`; legal range 2..255.

- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-low; one clock domain, with `reset` low forcing the reset state immediately.
- `start` in 1: operation request; sampled only in IDLE.
- `operand_a` in 4: operand A, captured when `start` is accepted.
- `operand_b` in 4: operand B, captured when `start` is accepted.
- `op_sel` in 2: ALU operation (00 ADD, 01 SUB, 10 MUL, 11 DIV), captured when `start` is accepted.
- `busy` out 1: high in every state except IDLE.
- `dp_data` out 4: operand to the datapath `data_in`.
- `dp_op_code` out 3: instruction to the datapath (000 NOP, 001 LOAD A, 011 LOAD B, 100 COMPUTE).
- `dp_compute_op` out 2: the captured `op_sel`, held stable for the whole transaction.
- `dp_result` in 8, `dp_done` in 1, `dp_negative` in 1, `dp_div_by_zero` in 1: datapath outputs.
- `result` out 8, `negative` out 1, `div_by_zero` out 1: captured outputs, held until the next capture.
- `valid` out 1: one-cycle pulse when a new result is captured.
- `timeout_err` out 1: sticky error flag; cleared on the next accepted `start`.

## Operation
- States: IDLE, LOAD_A, LOAD_B, COMPUTE, REPORT. Moore outputs are registered from state.
- IDLE: `dp_op_code`=000 and `dp_data`=0.
  - `start`=1 at an edge captures `operand_a`, `operand_b` and `op_sel`, clears `timeout_err`, and moves to LOAD_A.
- LOAD_A: `dp_op_code`=001 and `dp_data`=A. Next state is LOAD_B after exactly 1 cycle.
- LOAD_B: `dp_op_code`=011 and `dp_data`=B. Next state is COMPUTE after exactly 1 cycle.
- COMPUTE: `dp_op_code`=100, `dp_data`=0, and the timeout counter increments every cycle.
  - If `dp_done`=1 at an edge: latch `dp_result`, `dp_negative` and `dp_div_by_zero`, then go to REPORT.
  - Otherwise, at the edge where the counter reaches `TIMEOUT_CYCLES`: set `timeout_err`, leave `result` and flags unchanged, and go to IDLE.
- REPORT: `valid`=1 and `dp_op_code`=000. Next state is IDLE after 1 cycle.
- Boundary rules:
  - `start` outside IDLE is ignored and not queued.
  - `start` held high starts a new transaction on the first IDLE edge, so back-to-back transactions are spaced by exactly one IDLE cycle.
  - `dp_done` outside COMPUTE is ignored.
  - `dp_done` and timeout expiry at the same edge: done wins, no error is flagged.
  - The timeout counter clears on entry to COMPUTE; it is 8 bits wide and never wraps (saturates at expiry).
  - `reset` asserted mid-transaction aborts it with no `valid`; the datapath sees NOP immediately.

## Timing
- Reset values:
  - state IDLE
  - `dp_op_code`=000, `dp_data`=0, `dp_compute_op`=00
  - `result`=0x00, `negative`=0, `div_by_zero`=0
  - `valid`=0, `busy`=0, `timeout_err`=0
- Start accepted at edge n:
  - LOAD A is presented in cycle n+1.
  - LOAD B is presented in cycle n+2.
  - COMPUTE is presented from cycle n+3.
- `dp_done` sampled high at edge m (m ≥ n+3): `result` and flags update at edge m, and `valid` is high for cycle m+1.
- Minimum start-to-`valid` latency is 4 cycles.
- Timeout expires at edge n+2+`TIMEOUT_CYCLES` if no done is seen.
- `busy` falls in the cycle after REPORT, or after timeout expiry.

## Configuration
- `CALC_SEQ_TIMEOUT_EN`
  - Defined: the timeout counter and `timeout_err` behave as described above.
  - Undefined: no counter is built, COMPUTE waits indefinitely for `dp_done`, and `timeout_err` is tied 0.

## Test plan
- ADD, A=3, B=5, `op_sel`=00, with the datapath model finishing in 1 cycle -> `dp_op_code` sequence 001, 011, 100; `result`=0x08 and `valid` pulse 4 cycles after start.
- SUB, A=2, B=7, model returns 0x05 with negative=1 -> `result`=0x05, `negative`=1, `div_by_zero`=0.
- DIV, A=9, B=0, model asserts div_by_zero -> `div_by_zero`=1, exactly one `valid` pulse.
- `start` pulsed during LOAD_B; then `start` held high for 20 cycles -> the first pulse is ignored; held start yields transactions whose `valid` pulses are 5 cycles apart.
- Model never asserts done, `TIMEOUT_CYCLES`=16 -> `timeout_err`=1 and IDLE after 16 COMPUTE cycles, no `valid`, `result` unchanged; the next start clears `timeout_err`.
- `reset` driven low for 1 cycle in COMPUTE -> all outputs at reset values before the next edge, no `valid`, new transaction works afterwards.

Source files
------------

// File: rtl/calculator_sequencer.sv
// rtl/calculator_sequencer.sv - instruction sequencer for the 4-bit calculator datapath (timeout option: CALC_SEQ_TIMEOUT_EN)
module calculator_sequencer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] operand_a,
  input  logic [3:0] operand_b,
  input  logic [1:0] op_sel,
  output logic       busy,
  output logic [3:0] dp_data,
  output logic [2:0] dp_op_code,
  output logic [1:0] dp_compute_op,
  input  logic [7:0] dp_result,
  input  logic       dp_done,
  input  logic       dp_negative,
  input  logic       dp_div_by_zero,
  output logic [7:0] result,
  output logic       negative,
  output logic       div_by_zero,
  output logic       valid,
  output logic       timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_COMPUTE,
    S_REPORT
  } state_t;

  localparam logic [2:0] OP_NOP     = 3'b000;
  localparam logic [2:0] OP_LOAD_A  = 3'b001;
  localparam logic [2:0] OP_LOAD_B  = 3'b011;
  localparam logic [2:0] OP_COMPUTE = 3'b100;

  // Reject out-of-range timeouts at elaboration; the counter is only 8 bits.
  if ((TIMEOUT_CYCLES < 2) || (TIMEOUT_CYCLES > 255)) begin : g_bad_timeout
    $error("calculator_sequencer: TIMEOUT_CYCLES must be in 2..255");
  end

  state_t     r_state;
  logic [3:0] r_op_b;
  logic [3:0] r_dp_data;
  logic [2:0] r_op_code;
  logic [1:0] r_compute_op;
  logic [7:0] r_result;
  logic       r_negative;
  logic       r_div_by_zero;
  logic       r_valid;
  logic       r_busy;

`ifdef CALC_SEQ_TIMEOUT_EN
  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);

  logic [7:0] r_tmo_cnt;
  logic       r_timeout_err;
  logic       w_tmo_expire;

  // Expiry is seen on the edge that brings the count up to TIMEOUT_CYCLES.
  assign w_tmo_expire = (r_tmo_cnt == (TMO_LIMIT - 8'd1));
`endif

  // Sequencer FSM; every datapath-facing output is registered alongside the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_op_b        <= 4'd0;
      r_dp_data     <= 4'd0;
      r_op_code     <= OP_NOP;
      r_compute_op  <= 2'd0;
      r_result      <= 8'd0;
      r_negative    <= 1'b0;
      r_div_by_zero <= 1'b0;
      r_valid       <= 1'b0;
      r_busy        <= 1'b0;
`ifdef CALC_SEQ_TIMEOUT_EN
      r_tmo_cnt     <= 8'd0;
      r_timeout_err <= 1'b0;
`endif
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op_b       <= operand_b;
            r_compute_op <= op_sel;
            r_dp_data    <= operand_a;
            r_op_code    <= OP_LOAD_A;
            r_busy       <= 1'b1;
            r_state      <= S_LOAD_A;
`ifdef CALC_SEQ_TIMEOUT_EN
            r_timeout_err <= 1'b0;
`endif
          end
        end
        S_LOAD_A: begin
          r_dp_data <= r_op_b;
          r_op_code <= OP_LOAD_B;
          r_state   <= S_LOAD_B;
        end
        S_LOAD_B: begin
          r_dp_data <= 4'd0;
          r_op_code <= OP_COMPUTE;
          r_state   <= S_COMPUTE;
`ifdef CALC_SEQ_TIMEOUT_EN
          r_tmo_cnt <= 8'd0;
`endif
        end
        S_COMPUTE: begin
`ifdef CALC_SEQ_TIMEOUT_EN
          // Saturating count; the state is left at expiry so it never wraps.
          if (r_tmo_cnt != TMO_LIMIT) begin
            r_tmo_cnt <= r_tmo_cnt + 8'd1;
          end
`endif
          // Done takes priority over a coincident timeout expiry.
          if (dp_done) begin
            r_result      <= dp_result;
            r_negative    <= dp_negative;
            r_div_by_zero <= dp_div_by_zero;
            r_valid       <= 1'b1;
            r_op_code     <= OP_NOP;
            r_state       <= S_REPORT;
          end
`ifdef CALC_SEQ_TIMEOUT_EN
          else if (w_tmo_expire) begin
            r_timeout_err <= 1'b1;
            r_op_code     <= OP_NOP;
            r_busy        <= 1'b0;
            r_state       <= S_IDLE;
          end
`endif
        end
        S_REPORT: begin
          r_op_code <= OP_NOP;
          r_dp_data <= 4'd0;
          r_busy    <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: begin
          r_op_code <= OP_NOP;
          r_dp_data <= 4'd0;
          r_busy    <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign busy          = r_busy;
  assign dp_data       = r_dp_data;
  assign dp_op_code    = r_op_code;
  assign dp_compute_op = r_compute_op;
  assign result        = r_result;
  assign negative      = r_negative;
  assign div_by_zero   = r_div_by_zero;
  assign valid         = r_valid;
`ifdef CALC_SEQ_TIMEOUT_EN
  assign timeout_err   = r_timeout_err;
`else
  assign timeout_err   = 1'b0;
`endif

endmodule

// File: tb/tb_calculator_sequencer.sv
// tb/tb_calculator_sequencer.sv - self-checking bench for calculator_sequencer
module tb_calculator_sequencer;

  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] operand_a, operand_b;
  logic [1:0] op_sel;
  logic       busy;
  logic [3:0] dp_data;
  logic [2:0] dp_op_code;
  logic [1:0] dp_compute_op;
  logic [7:0] dp_result;
  logic       dp_done, dp_negative, dp_div_by_zero;
  logic [7:0] result;
  logic       negative, div_by_zero, valid, timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  // datapath model controls
  logic       stray_done = 1'b0;
  logic       never_done = 1'b0;
  int         done_delay = 0;
  int         cc = 0;
  logic [3:0] ma = 4'd0, mb = 4'd0;
  logic [7:0] exp_hold = 8'd0;

  always #5 clk = ~clk;

  calculator_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .start(start),
    .operand_a(operand_a), .operand_b(operand_b), .op_sel(op_sel),
    .busy(busy), .dp_data(dp_data), .dp_op_code(dp_op_code), .dp_compute_op(dp_compute_op),
    .dp_result(dp_result), .dp_done(dp_done), .dp_negative(dp_negative), .dp_div_by_zero(dp_div_by_zero),
    .result(result), .negative(negative), .div_by_zero(div_by_zero),
    .valid(valid), .timeout_err(timeout_err)
  );

  // Reference ALU: {div_by_zero, negative, result[7:0]}
  function automatic logic [9:0] alu(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
    logic [7:0] r;
    logic n, z;
    r = 8'd0; n = 1'b0; z = 1'b0;
    case (op)
      2'd0: r = 8'(a) + 8'(b);
      2'd1: if (b > a) begin r = 8'(b) - 8'(a); n = 1'b1; end else r = 8'(a) - 8'(b);
      2'd2: r = 8'(a) * 8'(b);
      default: if (b == 4'd0) z = 1'b1; else r = 8'(a) / 8'(b);
    endcase
    return {z, n, r};
  endfunction

  // Datapath model: latch operands from the presented instructions, count COMPUTE cycles.
  always @(posedge clk) begin
    if (dp_op_code == 3'b100) cc <= cc + 1; else cc <= 0;
    if (dp_op_code == 3'b001) ma <= dp_data;
    if (dp_op_code == 3'b011) mb <= dp_data;
  end

  always_comb begin
    dp_done = stray_done | ((dp_op_code == 3'b100) && !never_done && (cc == done_delay));
    {dp_div_by_zero, dp_negative, dp_result} = alu(ma, mb, dp_compute_op);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One full transaction, entered and left on a falling edge.
  task automatic run_txn(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op,
                         input int delay, input bit stray,
                         input logic [7:0] er, input logic en, input logic ez);
    int  lat;
    bit  seen;
    operand_a = a; operand_b = b; op_sel = op;
    done_delay = delay; stray_done = stray; start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("load_a_op", dp_op_code, 3'b001);
    chk("load_a_data", dp_data, a);
    chk("busy_load_a", busy, 1'b1);
    chk("compute_op", dp_compute_op, op);
    chk("tmo_err_cleared", timeout_err, 1'b0);
    @(negedge clk);
    chk("load_b_op", dp_op_code, 3'b011);
    chk("load_b_data", dp_data, b);
    @(negedge clk);
    stray_done = 1'b0;
    chk("compute_op_code", dp_op_code, 3'b100);
    chk("compute_data", dp_data, 4'd0);
    lat = 3; seen = 1'b0;
    while (lat < 60 && !seen) begin
      @(negedge clk); lat++;
      if (valid) seen = 1'b1;
    end
    chk("valid_seen", seen, 1'b1);
    chk("latency", lat, 4 + delay);
    chk("result", result, er);
    chk("negative", negative, en);
    chk("div_by_zero", div_by_zero, ez);
    chk("report_op", dp_op_code, 3'b000);
    chk("report_busy", busy, 1'b1);
    chk("report_no_err", timeout_err, 1'b0);
    exp_hold = er;
    @(negedge clk);
    chk("valid_single", valid, 1'b0);
    chk("busy_after", busy, 1'b0);
  endtask

  typedef struct {
    logic [3:0] a, b;
    logic [1:0] op;
    int         delay;
    bit         stray;
    logic [7:0] er;
    logic       en, ez;
  } vec_t;

  vec_t vecs[8];
  int   vq[$];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{4'd3,  4'd5,  2'd0, 0,  1'b0, 8'h08, 1'b0, 1'b0};
    vecs[1] = '{4'd2,  4'd7,  2'd1, 0,  1'b0, 8'h05, 1'b1, 1'b0};
    vecs[2] = '{4'd9,  4'd0,  2'd3, 0,  1'b0, 8'h00, 1'b0, 1'b1};
    vecs[3] = '{4'd15, 4'd15, 2'd2, 1,  1'b0, 8'hE1, 1'b0, 1'b0};
    vecs[4] = '{4'd13, 4'd4,  2'd3, 2,  1'b1, 8'h03, 1'b0, 1'b0};
    vecs[5] = '{4'd15, 4'd15, 2'd0, 3,  1'b0, 8'h1E, 1'b0, 1'b0};
    vecs[6] = '{4'd9,  4'd4,  2'd1, 15, 1'b0, 8'h05, 1'b0, 1'b0};
    vecs[7] = '{4'd0,  4'd0,  2'd1, 0,  1'b1, 8'h00, 1'b0, 1'b0};

    reset = 1'b0; start = 1'b0; operand_a = 4'd0; operand_b = 4'd0; op_sel = 2'd0;
    #2;
    chk("rst_op_code", dp_op_code, 3'b000);
    chk("rst_outputs", {busy, dp_data, dp_compute_op, result, negative, div_by_zero, valid, timeout_err}, 0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 1'b0);

    // directed table
    for (int i = 0; i < 8; i++)
      run_txn(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].delay, vecs[i].stray,
              vecs[i].er, vecs[i].en, vecs[i].ez);

    // done asserted while idle is ignored
    stray_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stray_idle_valid", valid, 1'b0);
      chk("stray_idle_busy", busy, 1'b0);
    end
    stray_done = 1'b0;
    chk("stray_idle_result", result, exp_hold);

    // start during LOAD_B is ignored, then held start gives back-to-back transactions
    operand_a = 4'd6; operand_b = 4'd3; op_sel = 2'd2; done_delay = 0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); start = 1'b1;
    chk("lb_op", dp_op_code, 3'b011);
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 10 && busy; i++) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_queued_start", busy, 1'b0);
    end
    start = 1'b1;
    vq.delete();
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (valid) vq.push_back(i);
    end
    start = 1'b0;
    chk("held_valid_count", vq.size(), 4);
    if (vq.size() > 0) chk("held_first_valid", vq[0], 4);
    for (int i = 1; i < vq.size(); i++) chk("held_spacing", vq[i] - vq[i-1], 5);
    chk("held_result", result, 8'h12);
    exp_hold = 8'h12;
    @(negedge clk); @(negedge clk);
    chk("held_idle", busy, 1'b0);

    // no done from the datapath
    never_done = 1'b1;
    operand_a = 4'd1; operand_b = 4'd1; op_sel = 2'd0; start = 1'b1;
`ifdef CALC_SEQ_TIMEOUT_EN
    for (int k = 1; k <= TMO + 3; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      chk("tmo_no_valid", valid, 1'b0);
      if (k == TMO + 2) begin
        chk("tmo_busy_before", busy, 1'b1);
        chk("tmo_err_before", timeout_err, 1'b0);
      end
      if (k == TMO + 3) begin
        chk("tmo_busy_after", busy, 1'b0);
        chk("tmo_err_after", timeout_err, 1'b1);
        chk("tmo_result_kept", result, exp_hold);
        chk("tmo_nop", dp_op_code, 3'b000);
      end
    end
    @(negedge clk); @(negedge clk);
    chk("tmo_err_sticky", timeout_err, 1'b1);
    never_done = 1'b0;
    run_txn(4'd4, 4'd4, 2'd0, 0, 1'b0, 8'h08, 1'b0, 1'b0);
    never_done = 1'b1;
    operand_a = 4'd1; operand_b = 4'd1; op_sel = 2'd0; start = 1'b1;
`else
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      chk("wait_no_valid", valid, 1'b0);
      chk("wait_busy", busy, 1'b1);
      chk("wait_no_err", timeout_err, 1'b0);
    end
    start = 1'b1;
`endif

    // reset mid-COMPUTE
    @(negedge clk); start = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("pre_reset_compute", dp_op_code, 3'b100);
    reset = 1'b0;
    #1;
    chk("async_rst_op", dp_op_code, 3'b000);
    chk("async_rst_outs", {busy, dp_data, dp_compute_op, result, negative, div_by_zero, valid, timeout_err}, 0);
    @(negedge clk);
    reset = 1'b1;
    never_done = 1'b0;
    exp_hold = 8'h00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_valid", valid, 1'b0);
      chk("post_rst_busy", busy, 1'b0);
    end
    run_txn(4'd7, 4'd2, 2'd1, 0, 1'b0, 8'h05, 1'b0, 1'b0);

    // randomized transactions against the reference ALU
    for (int i = 0; i < 30; i++) begin
      logic [3:0] ra, rb;
      logic [1:0] rop;
      logic [9:0] e;
      ra  = 4'($urandom_range(0, 15));
      rb  = 4'($urandom_range(0, 15));
      rop = 2'($urandom_range(0, 3));
      e   = alu(ra, rb, rop);
      run_txn(ra, rb, rop, $urandom_range(0, 6), 1'($urandom_range(0, 1)), e[7:0], e[8], e[9]);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
